rle_dpcm_mc: RTL

// Parametrised multi-channel run-length encoder for quantised, zig-zag ordered coefficient blocks.

---
 rtl/rle_dpcm_mc.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rle_dpcm_mc.sv
// Multi-channel run-length encoder for quantised zig-zag coefficient blocks.
// Each block starts with a DC coefficient that is DPCM coded against a
// per-channel predictor. The AC coefficients that follow become JPEG style
// (run, value) symbols, with ZRL (15,0) and EOB markers. Symbols carry their
// size category and leave through a small valid/ready FIFO.
module rle_dpcm_mc #(
  parameter int DW     = 12,
  parameter int BLK    = 64,
  parameter int NCH    = 3,
  parameter int FDEPTH = 4,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] in_data,
  input  logic [CW-1:0]        in_ch,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 dc_clear,
  output logic [3:0]           out_run,
  output logic signed [DW:0]   out_val,
  output logic [3:0]           out_size,
  output logic                 out_isdc,
  output logic                 out_iseob,
  output logic [CW-1:0]        out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int IW = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int NW = $clog2(FDEPTH + 1);
  localparam int VW = DW + 1;

  typedef enum logic [0:0] {S_RUN, S_ZRL} state_t;

  typedef struct packed {
    logic [3:0]           run;
    logic signed [VW-1:0] val;
    logic [3:0]           size;
    logic                 isdc;
    logic                 iseob;
    logic [CW-1:0]        ch;
  } sym_t;

  // Size category: bit length of the magnitude, 0 for a zero value.
  function automatic logic [3:0] size_of(input logic signed [VW-1:0] v);
    logic [VW-1:0] mag;
    logic [3:0]    sz;
    mag = v[VW-1] ? (~v + 1'b1) : v;
    sz  = '0;
    for (int i = 0; i < VW; i++) begin
      if (mag[i]) sz = 4'(i + 1);
    end
    return sz;
  endfunction

  state_t               state, state_n;
  logic [IW-1:0]        idx, idx_n;
  logic [3:0]           zrun, zrun_n;
  logic [1:0]           zrl_cnt, zrl_n;
  logic [CW-1:0]        blk_ch, blk_ch_n;
  logic [3:0]           hold_run, hold_run_n;
  logic signed [VW-1:0] hold_val, hold_val_n;
  logic signed [DW-1:0] pred [NCH];

  sym_t                 mem [FDEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [NW-1:0]        count;
  sym_t                 head;

  logic                 accept, pop, space, push, dc_write;
  logic signed [DW-1:0] pred_sel;
  logic signed [VW-1:0] diff;
  logic [3:0]           p_run;
  logic signed [VW-1:0] p_val;
  logic                 p_isdc, p_iseob;
  logic [CW-1:0]        p_ch;
  sym_t                 push_sym;

  assign space     = (count < NW'(FDEPTH));
  assign in_ready  = !rst && (state == S_RUN) && space;
  assign accept    = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign dc_write  = accept && (idx == '0);

  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_run   = head.run;
  assign out_val   = head.val;
  assign out_size  = head.size;
  assign out_isdc  = head.isdc;
  assign out_iseob = head.iseob;
  assign out_ch    = head.ch;

  // Predictor lookup for the DC difference; a coincident clear means predict from 0.
  always_comb begin
    pred_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (in_ch == CW'(c)) pred_sel = pred[c];
    end
    if (dc_clear) pred_sel = '0;
    diff = {in_data[DW-1], in_data} - {pred_sel[DW-1], pred_sel};
  end

  // Encoder next-state logic: run counting, ZRL accounting and symbol selection.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    zrun_n     = zrun;
    zrl_n      = zrl_cnt;
    blk_ch_n   = blk_ch;
    hold_run_n = hold_run;
    hold_val_n = hold_val;
    push       = 1'b0;
    p_run      = '0;
    p_val      = '0;
    p_isdc     = 1'b0;
    p_iseob    = 1'b0;
    p_ch       = blk_ch;
    case (state)
      S_RUN: begin
        if (accept) begin
          idx_n = (idx == IW'(BLK - 1)) ? '0 : idx + 1'b1;
          if (idx == '0) begin
            push     = 1'b1;
            p_val    = diff;
            p_isdc   = 1'b1;
            p_ch     = in_ch;
            blk_ch_n = in_ch;
            zrun_n   = '0;
            zrl_n    = '0;
          end else if (in_data == '0) begin
            if (idx == IW'(BLK - 1)) begin
              push    = 1'b1;
              p_iseob = 1'b1;
              zrun_n  = '0;
              zrl_n   = '0;
            end else if (zrun == 4'd15) begin
              zrun_n = '0;
              if (zrl_cnt != 2'd3) zrl_n = zrl_cnt + 2'd1;
            end else begin
              zrun_n = zrun + 4'd1;
            end
          end else begin
            zrun_n = '0;
            if (zrl_cnt == '0) begin
              push  = 1'b1;
              p_run = zrun;
              p_val = {in_data[DW-1], in_data};
            end else begin
              hold_run_n = zrun;
              hold_val_n = {in_data[DW-1], in_data};
              state_n    = S_ZRL;
            end
          end
        end
      end
      S_ZRL: begin
        if (space) begin
          push = 1'b1;
          if (zrl_cnt != '0) begin
            p_run = 4'd15;
            zrl_n = zrl_cnt - 2'd1;
          end else begin
            p_run   = hold_run;
            p_val   = hold_val;
            state_n = S_RUN;
          end
        end
      end
      default: state_n = S_RUN;
    endcase
  end

  // Assemble the symbol with its size category before it enters the FIFO.
  always_comb begin
    push_sym       = '0;
    push_sym.run   = p_run;
    push_sym.val   = p_val;
    push_sym.size  = size_of(p_val);
    push_sym.isdc  = p_isdc;
    push_sym.iseob = p_iseob;
    push_sym.ch    = p_ch;
  end

  // Encoder state registers; reset drops any partial block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      idx      <= '0;
      zrun     <= '0;
      zrl_cnt  <= '0;
      blk_ch   <= '0;
      hold_run <= '0;
      hold_val <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      zrun     <= zrun_n;
      zrl_cnt  <= zrl_n;
      blk_ch   <= blk_ch_n;
      hold_run <= hold_run_n;
      hold_val <= hold_val_n;
    end
  end

  // DC predictors: clear on restart, then the accepted DC overwrites its own channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) pred[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (dc_clear) pred[c] <= '0;
        if (dc_write && (in_ch == CW'(c))) pred[c] <= in_data;
      end
    end
  end

  // Output symbol FIFO with simultaneous push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_sym;
        wr_ptr      <= (wr_ptr == PW'(FDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
